phase_sequencer: RTL and testbench
==================================

# phase_sequencer

- Sits directly downstream of the workshop tick counter and consumes its `complete` output as `tick`.
- Steps through `NUM_PHASES` phases, holding each phase for `DWELL_TICKS` tick events.
- Drives a one-hot phase bus and a phase index, and signals end of sequence with a one-cycle `done` pulse.
- Serves as the timing backbone for workshop sequencing demos, e.g. LED chasers and light controllers.

## Interface
- `NUM_PHASES`, default 4: number of phases; allowed range 2..16.
- `DWELL_WIDTH`, default 4: width of the dwell counter.
- `DWELL_TICKS`, default 3: tick events per phase; allowed range 1..2^DWELL_WIDTH-1.
- `clk`  input  1  single clock for the whole block; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `tick`  input  1  tick from the upstream counter; may be a pulse or a held level.
- `start`  input  1  begins a sequence when in IDLE.
- `stop`  input  1  aborts a running sequence.
- `busy`  output  1  high while a sequence is running.
- `phase`  output  NUM_PHASES  one-hot active phase; all zeros when not running.
- `phase_idx`  output  $clog2(NUM_PHASES)  binary index of the active phase.
- `done`  output  1  one-cycle pulse marking sequence completion.

## Operation
- **Tick edge detect**
  - Registered `tick_q` holds the previous cycle's `tick`.
  - `tick_rise = tick & ~tick_q`.
  - A held-high `tick` counts as exactly one event.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**
  - `busy=0`, `phase=0`, `phase_idx=0`, `dwell=0`.
  - `start` with `stop` low moves to RUN and sets `phase_idx=0`.
  - `tick_rise` is ignored.
- **RUN**
  - `busy=1`.
  - `phase` is the one-hot decode of `phase_idx`.
  - On each `tick_rise`, `dwell` increments.
  - When `tick_rise` arrives with `dwell==DWELL_TICKS-1`, `dwell` clears and:
    - if `phase_idx < NUM_PHASES-1`: `phase_idx` increments;
    - if `phase_idx == NUM_PHASES-1`: go to DONE (loop behaviour is covered under Configuration).
- **DONE**
  - Lasts exactly one cycle: `done=1`, `busy=0`, `phase=0`.
  - Always returns to IDLE.
  - `start` and `tick` are ignored.
- **Priorities**
  - `stop` in RUN or IDLE forces IDLE on the next edge and produces no `done`.
  - `stop` beats `tick_rise` and `start` when they occur in the same cycle.
  - `start` while in RUN is ignored; it does not restart the sequence.
- **Arithmetic:** `dwell` is unsigned `DWELL_WIDTH` bits and never wraps, because it clears at `DWELL_TICKS-1`.
- **Reset:** while `reset=0` at a clock edge, the block returns to IDLE immediately, including mid-sequence:
  - `tick_q=0`, `dwell=0`, `phase_idx=0`;
  - `busy=0`, `phase=0`, `done=0`.

## Timing
- All outputs are registered; none has a combinational path from any input.
- `start` sampled at edge N gives `busy=1` and `phase=1` after edge N.
- `tick` rising at edge N:
  - `dwell` or the phase changes after edge N;
  - `tick_q` equals `tick` after edge N.
- Final tick of the last phase at edge N:
  - `done=1` and `busy=0` after edge N;
  - `done=0` after edge N+1.
- With `DWELL_TICKS=1`, every tick rise advances the phase.
- A tick that is already high when `start` is accepted does not count. The edge detector ran during IDLE, so `tick_q` is already high.
- Minimum spacing between tick events is 2 cycles: high for one cycle, low for one cycle.

## Configuration
- Macro: `PHASE_SEQ_LOOP_EN`.
- **Defined:** finishing the last phase:
  - pulses `done` for one cycle;
  - sets `phase_idx=0`;
  - stays in RUN with `busy=1`.
  - DONE is never entered, and only `stop` or `reset` ends the sequence.
- **Undefined:** one-shot behaviour exactly as described under Operation.

## Test plan
All scenarios use `NUM_PHASES=4`, `DWELL_TICKS=3`.
- **Reset mid-run:** `start`, 5 tick pulses, then `reset=0` for one cycle → `busy=0`, `phase=0`, `phase_idx=0`, `done=0` the next cycle; a later `start` begins again at phase 0.
- **One-shot sequence:** `start`, then 12 single-cycle tick pulses → `phase` steps 0001, 0010, 0100, 1000, changing on ticks 3, 6 and 9; tick 12 gives `done=1` for exactly 1 cycle, then IDLE.
- **Held-level tick:** `start`, then `tick` held high for 10 cycles → `dwell` advances by exactly 1 and `phase` stays 0001.
- **Stop with simultaneous tick:** `stop` and the 3rd tick rise in the same cycle → IDLE with `phase=0`; no `done` and no phase advance.
- **Ignored inputs:** `start` pulsed in RUN at phase 2 → sequence continues unchanged. Tick pulses in IDLE followed by `start` → phase 0001, `dwell=0`.
- **Loop mode (`PHASE_SEQ_LOOP_EN` defined):** 24 tick pulses → `done` pulses after ticks 12 and 24; `busy` stays 1; `phase` returns to 0001 after tick 12.

Source files
------------

// File: rtl/phase_sequencer.sv
// Tick-driven phase sequencer: steps through NUM_PHASES phases, DWELL_TICKS tick rises each.
// Optional macro PHASE_SEQ_LOOP_EN: wrap to phase 0 after the last phase instead of stopping.
module phase_sequencer #(
    parameter int NUM_PHASES  = 4,
    parameter int DWELL_WIDTH = 4,
    parameter int DWELL_TICKS = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    output logic                          busy,
    output logic [NUM_PHASES-1:0]         phase,
    output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
    output logic                          done
);
    localparam int IDX_W = $clog2(NUM_PHASES);
    localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL_TICKS - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   tick_q;
    logic [DWELL_WIDTH-1:0] dwell_reg;
    logic                   tick_rise;
    logic [IDX_W-1:0]       idx_inc;
    logic [NUM_PHASES-1:0]  phase_inc;

    assign tick_rise = tick & ~tick_q;
    assign idx_inc   = phase_idx + IDX_W'(1);

    // One-hot of the following phase, ready for the registered phase bus.
    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_decode
            assign phase_inc[gi] = (idx_inc == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            tick_q    <= 1'b0;
            dwell_reg <= '0;
            phase_idx <= '0;
            busy      <= 1'b0;
            phase     <= '0;
            done      <= 1'b0;
        end else begin
            // The edge detector runs in every state so a tick already high at start is not counted.
            tick_q <= tick;
            done   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy      <= 1'b0;
                    phase     <= '0;
                    phase_idx <= '0;
                    dwell_reg <= '0;
                    if (start && !stop) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        phase     <= NUM_PHASES'(1);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        phase     <= '0;
                        phase_idx <= '0;
                        dwell_reg <= '0;
                    end else if (tick_rise) begin
                        if (dwell_reg == DWELL_LAST) begin
                            dwell_reg <= '0;
                            if (phase_idx != IDX_LAST) begin
                                phase_idx <= idx_inc;
                                phase     <= phase_inc;
                            end else begin
                                done      <= 1'b1;
                                phase_idx <= '0;
`ifdef PHASE_SEQ_LOOP_EN
                                phase     <= NUM_PHASES'(1);
`else
                                state_reg <= DONE;
                                busy      <= 1'b0;
                                phase     <= '0;
`endif
                            end
                        end else begin
                            dwell_reg <= dwell_reg + DWELL_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    phase     <= '0;
                    phase_idx <= '0;
                    dwell_reg <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    phase     <= '0;
                    phase_idx <= '0;
                    dwell_reg <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer (NUM_PHASES=4, DWELL_TICKS=3): vector table plus
// hand-written multi-cycle sequences, all checked through an expected-result queue.
module tb_phase_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic [3:0] phase;
    logic [1:0] phase_idx;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    phase_sequencer #(
        .NUM_PHASES (4),
        .DWELL_WIDTH(4),
        .DWELL_TICKS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .phase    (phase),
        .phase_idx(phase_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        logic [3:0] phase;
        logic [1:0] idx;
        logic       done;
        logic       idx_care;
        string      tag;
    } exp_t;

    typedef struct {
        logic       r, t, s, p;
        logic       busy;
        logic [3:0] phase;
        logic [1:0] idx;
        logic       done;
    } vec_t;

    exp_t sb[$];

    task automatic check_out();
        exp_t e;
        logic ok;
        e  = sb.pop_front();
        n_cmp++;
        ok = (busy === e.busy) && (phase === e.phase) && (done === e.done) &&
             (!e.idx_care || phase_idx === e.idx);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got busy=%0b phase=%b idx=%0d done=%0b, want busy=%0b phase=%b idx=%0d done=%0b",
                     e.tag, busy, phase, phase_idx, done, e.busy, e.phase, e.idx, e.done);
        end else begin
            $display("ok   %s: busy=%0b phase=%b idx=%0d done=%0b", e.tag, busy, phase, phase_idx, done);
        end
    endtask

    task automatic step(input logic r, t, s, p, input logic eb, input logic [3:0] eph,
                        input logic [1:0] eidx, input logic ed, input logic care, input string tag);
        exp_t e;
        @(negedge clk);
        reset = r; tick = t; start = s; stop = p;
        e = '{eb, eph, eidx, ed, care, tag};
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_step(input logic t, s, p, input int idx, input string tag);
        step(1'b1, t, s, p, 1'b1, 4'b0001 << idx, 2'(idx), 1'b0, 1'b1, tag);
    endtask

    task automatic idle_step(input logic t, s, p, input string tag);
        step(1'b1, t, s, p, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, tag);
    endtask

    vec_t vecs[23];

    initial begin
        // r t s p | busy phase idx done
        vecs[0]  = '{0, 0, 0, 0, 0, 4'b0000, 0, 0};  // reset
        vecs[1]  = '{1, 1, 0, 0, 0, 4'b0000, 0, 0};  // tick ignored in IDLE
        vecs[2]  = '{1, 0, 0, 0, 0, 4'b0000, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, 4'b0000, 0, 0};
        vecs[4]  = '{1, 1, 1, 0, 1, 4'b0001, 0, 0};  // start with tick already high
        vecs[5]  = '{1, 1, 0, 0, 1, 4'b0001, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 1, 4'b0001, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 1, 4'b0001, 0, 0};  // rise 1
        vecs[8]  = '{1, 0, 0, 0, 1, 4'b0001, 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 1, 4'b0001, 0, 0};  // rise 2
        vecs[10] = '{1, 0, 0, 0, 1, 4'b0001, 0, 0};
        vecs[11] = '{1, 1, 0, 0, 1, 4'b0010, 1, 0};  // rise 3 advances
        vecs[12] = '{1, 0, 0, 0, 1, 4'b0010, 1, 0};
        vecs[13] = '{1, 0, 1, 0, 1, 4'b0010, 1, 0};  // start in RUN ignored
        vecs[14] = '{1, 0, 0, 1, 0, 4'b0000, 0, 0};  // stop
        vecs[15] = '{1, 0, 1, 1, 0, 4'b0000, 0, 0};  // stop beats start
        vecs[16] = '{1, 0, 1, 0, 1, 4'b0001, 0, 0};
        vecs[17] = '{1, 1, 0, 0, 1, 4'b0001, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 1, 4'b0001, 0, 0};
        vecs[19] = '{1, 1, 0, 0, 1, 4'b0001, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 1, 4'b0001, 0, 0};
        vecs[21] = '{1, 1, 0, 1, 0, 4'b0000, 0, 0};  // stop with 3rd tick rise
        vecs[22] = '{1, 0, 0, 0, 0, 4'b0000, 0, 0};

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].p, vecs[i].busy, vecs[i].phase,
                 vecs[i].idx, vecs[i].done, 1'b1, $sformatf("vec[%0d]", i));
        end

        // Reset mid-run: dwell must be cleared, so 3 fresh ticks advance again.
        run_step(0, 1, 0, 0, "rst start");
        for (int k = 1; k <= 5; k++) begin
            run_step(1, 0, 0, k / 3, $sformatf("rst tick%0d hi", k));
            run_step(0, 0, 0, k / 3, $sformatf("rst tick%0d lo", k));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, "rst assert");
        run_step(0, 1, 0, 0, "rst restart");
        for (int k = 1; k <= 3; k++) begin
            run_step(1, 0, 0, k / 3, $sformatf("rst2 tick%0d hi", k));
            run_step(0, 0, 0, k / 3, $sformatf("rst2 tick%0d lo", k));
        end
        idle_step(0, 0, 1, "rst2 stop");

        // Full sequence; start pulsed at phase 2 must be ignored.
        run_step(0, 1, 0, 0, "seq start");
`ifdef PHASE_SEQ_LOOP_EN
        for (int k = 1; k <= 24; k++) begin
            int m;
            m = k % 12;
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001 << (m / 3), 2'(m / 3), (m == 0), 1'b1,
                 $sformatf("loop tick%0d hi", k));
            run_step(0, (k == 7), 0, m / 3, $sformatf("loop tick%0d lo", k));
        end
        idle_step(0, 0, 1, "loop stop");
`else
        for (int k = 1; k <= 12; k++) begin
            if (k < 12) begin
                run_step(1, 0, 0, k / 3, $sformatf("seq tick%0d hi", k));
                run_step(0, (k == 7), 0, k / 3, $sformatf("seq tick%0d lo", k));
            end else begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, "seq last tick done");
                idle_step(0, 0, 0, "seq done drops");
            end
        end
        idle_step(1, 0, 0, "seq idle after");
        idle_step(0, 0, 0, "seq idle after2");
`endif

        // Held-level tick counts once: two more rises then complete the phase.
        run_step(0, 1, 0, 0, "held start");
        for (int c = 0; c < 10; c++) begin
            run_step(1, 0, 0, 0, $sformatf("held hi c%0d", c));
        end
        run_step(0, 0, 0, 0, "held lo");
        run_step(1, 0, 0, 0, "held rise2 hi");
        run_step(0, 0, 0, 0, "held rise2 lo");
        run_step(1, 0, 0, 1, "held rise3 hi");
        idle_step(0, 0, 1, "held stop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
